bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter.
// Double-dabble, one shift per clock, start/busy/done handshake.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] i,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd5;

    state_t     state_q, state_d;
    logic [5:0] bin_q, bin_d;
    logic [7:0] scratch_q, scratch_d;
    logic [2:0] step_q, step_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0]  hi_adj;
    logic [3:0]  lo_adj;
    logic [13:0] shifted;

    // Add-3 correction must precede the shift so each nibble stays BCD.
    always_comb begin
        hi_adj  = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3
                                           : scratch_q[7:4];
        lo_adj  = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3
                                           : scratch_q[3:0];
        shifted = {hi_adj, lo_adj, bin_q} << 1;
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        step_d    = step_q;
        tens_d    = tens_q;
        units_d   = units_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = i;
                    scratch_d = 8'd0;
                    step_d    = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[13:6];
                bin_d     = shifted[5:0];
                step_d    = step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    tens_d  = shifted[13:10];
                    units_d = shifted[9:6];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= 6'd0;
            scratch_q <= 8'd0;
            step_q    <= 3'd0;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            step_q    <= step_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
